// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue: the decode NOP, default depth
// and the packed entry width {pc, inst, bp_pc, bp_taken, pc_re}.
`ifndef NOP
`define NOP 32'h0000_0013
`endif

package if_id_queue_pkg;

   localparam logic [31:0] NOP_INST      = `NOP;
   localparam int          IF_ID_Q_DEPTH = 4;

   // Entry layout is {pc, inst, bp_pc, bp_taken, pc_re}; every slice derives from this.
   function automatic int entry_w(input int width);
      return 3 * width + 2;
   endfunction

endpackage

// File: rtl/if_id_q_mem.sv
// Storage array of the IF/ID queue: DEPTH entries, one synchronous write port and
// one asynchronous read port.
module if_id_q_mem
   import if_id_queue_pkg::*;
#(
   parameter  int DATA_W = entry_w(32),
   parameter  int DEPTH  = IF_ID_Q_DEPTH,
   localparam int PTR_W  = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              i_we,
   input  logic [PTR_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [PTR_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // NOTE: data storage has no reset; validity is tracked by the pointers and count,
   // so resetting the array would only cost flops and a reset fan-out tree.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry IF/ID instruction queue with valid/ready on both sides and whole-queue kill.
// Optional same-cycle empty-queue bypass is enabled by defining IF_ID_Q_BYPASS_EN.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = IF_ID_Q_DEPTH,
   localparam int PTR_W = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_inst,
   input  logic             in_bp_taken,
   input  logic [WIDTH-1:0] in_bp_pc,
   input  logic             in_pc_re,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_inst,
   output logic             out_bp_taken,
   output logic [WIDTH-1:0] out_bp_pc,
   output logic             out_pc_re,
   input  logic             ctrl_flush,
   input  logic             ctrl_pc_re,
   input  logic             branch_miss,
   output logic [PTR_W:0]   count
);

   localparam int ENTRY_W = entry_w(WIDTH);

   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W:0]     r_count;
   logic               w_kill;
   logic               w_stored;
   logic               w_enq;
   logic               w_deq;
   logic               w_bypass_vis;
   logic               w_bypass_take;
   logic [ENTRY_W-1:0] w_wdata;
   logic [ENTRY_W-1:0] w_rdata;

   assign w_kill   = ctrl_flush | ctrl_pc_re | branch_miss;
   assign w_stored = (r_count != '0);
   assign in_ready = (r_count != (PTR_W+1)'(DEPTH));

`ifdef IF_ID_Q_BYPASS_EN
   assign w_bypass_vis  = !w_stored & in_valid & !w_kill;
   assign w_bypass_take = w_bypass_vis & out_ready;
`else
   assign w_bypass_vis  = 1'b0;
   assign w_bypass_take = 1'b0;
`endif

   // A bypassed entry consumed by decode in the same cycle is never written.
   assign w_enq     = in_valid & in_ready & !w_kill & !w_bypass_take;
   assign w_deq     = w_stored & out_ready;
   assign out_valid = w_stored | w_bypass_vis;
   assign count     = r_count;
   assign w_wdata   = {in_pc, in_inst, in_bp_pc, in_bp_taken, in_pc_re};

   if_id_q_mem #(
      .DATA_W (ENTRY_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_enq),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      out_pc       = '0;
      out_inst     = WIDTH'(NOP_INST);
      out_bp_pc    = '0;
      out_bp_taken = 1'b0;
      out_pc_re    = 1'b0;
      if (w_bypass_vis) begin
         out_pc       = in_pc;
         out_inst     = in_inst;
         out_bp_pc    = in_bp_pc;
         out_bp_taken = in_bp_taken;
         out_pc_re    = in_pc_re;
      end else if (w_stored) begin
         out_pc       = w_rdata[ENTRY_W-1 -: WIDTH];
         out_inst     = w_rdata[2*WIDTH+1 -: WIDTH];
         out_bp_pc    = w_rdata[WIDTH+1 -: WIDTH];
         out_bp_taken = w_rdata[1];
         out_pc_re    = w_rdata[0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_kill) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (default DEPTH=4, WIDTH=32).
module tb_if_id_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        in_bp_taken = 1'b0;
   logic [31:0] in_bp_pc = '0;
   logic        in_pc_re = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_bp_taken;
   logic [31:0] out_bp_pc;
   logic        out_pc_re;
   logic        ctrl_flush = 1'b0;
   logic        ctrl_pc_re = 1'b0;
   logic        branch_miss = 1'b0;
   logic [2:0]  count;

   int n_checks = 0;
   int n_errors = 0;

   if_id_queue dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_inst      (in_inst),
      .in_bp_taken  (in_bp_taken),
      .in_bp_pc     (in_bp_pc),
      .in_pc_re     (in_pc_re),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_inst     (out_inst),
      .out_bp_taken (out_bp_taken),
      .out_bp_pc    (out_bp_pc),
      .out_pc_re    (out_pc_re),
      .ctrl_flush   (ctrl_flush),
      .ctrl_pc_re   (ctrl_pc_re),
      .branch_miss  (branch_miss),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc);
      in_valid = 1'b1;
      in_pc    = pc;
      in_inst  = 32'hA000_0000 | pc;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset then idle
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_inst", out_inst, NOP);
      check("rst_out_pc", out_pc, 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_count", 32'(count), 0);

      // Dequeue request on empty queue is ignored
      out_ready = 1'b1;
      tick();
      check("empty_pop_count", 32'(count), 0);
      out_ready = 1'b0;

      // Fill to DEPTH, then reject a 5th push
      for (int i = 0; i < 4; i++) push(32'(4 * i));
      check("fill_count", 32'(count), 4);
      check("fill_in_ready", 32'(in_ready), 0);
      push(32'h10);
      check("full_count", 32'(count), 4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("pop_pc", out_pc, 32'(4 * i));
         check("pop_inst", out_inst, 32'hA000_0000 | 32'(4 * i));
         tick();
      end
      out_ready = 1'b0;
      check("drained_count", 32'(count), 0);
      check("drained_valid", 32'(out_valid), 0);
      check("drained_inst", out_inst, NOP);

      // Streaming: preload one, then 16 cycles of enqueue+dequeue
      push(32'h1000);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_pc   = 32'h1000 + 32'(4 * i);
         in_inst = 32'hA000_0000 | in_pc;
         #1;
         check("stream_pc", out_pc, 32'h1000 + 32'(4 * (i - 1)));
         tick();
         check("stream_count", 32'(count), 1);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      check("stream_drain", 32'(count), 0);

      // Kill via each source with a concurrent enqueue that must be dropped
      for (int k = 0; k < 3; k++) begin
         push(32'h30);
         push(32'h34);
         push(32'h38);
         check("prekill_count", 32'(count), 3);
         in_valid    = 1'b1;
         in_pc       = 32'h40;
         branch_miss = (k == 0);
         ctrl_flush  = (k == 1);
         ctrl_pc_re  = (k == 2);
         tick();
         in_valid    = 1'b0;
         branch_miss = 1'b0;
         ctrl_flush  = 1'b0;
         ctrl_pc_re  = 1'b0;
         check("kill_count", 32'(count), 0);
         check("kill_valid", 32'(out_valid), 0);
         check("kill_inst", out_inst, NOP);
         push(32'h50);
         check("postkill_pc", out_pc, 32'h50);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         check("postkill_empty", 32'(count), 0);
      end

      // Redirect / prediction tag follows only its own entry
      in_pc_re    = 1'b1;
      in_bp_taken = 1'b1;
      in_bp_pc    = 32'h200;
      push(32'h100);
      in_pc_re    = 1'b0;
      in_bp_taken = 1'b0;
      in_bp_pc    = 32'h0;
      push(32'h104);
      check("tag_pc", out_pc, 32'h100);
      check("tag_pc_re", 32'(out_pc_re), 1);
      check("tag_bp_taken", 32'(out_bp_taken), 1);
      check("tag_bp_pc", out_bp_pc, 32'h200);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("tag2_pc", out_pc, 32'h104);
      check("tag2_pc_re", 32'(out_pc_re), 0);
      check("tag2_bp_taken", 32'(out_bp_taken), 0);
      check("tag2_bp_pc", out_bp_pc, 32'h0);

      // Reset mid-stream (queue holds 104 plus one more)
      push(32'h108);
      check("premrst_count", 32'(count), 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_count", 32'(count), 0);
      check("mrst_valid", 32'(out_valid), 0);
      check("mrst_in_ready", 32'(in_ready), 1);

`ifdef IF_ID_Q_BYPASS_EN
      in_valid  = 1'b1;
      in_pc     = 32'h80;
      out_ready = 1'b1;
      #1;
      check("byp_valid", 32'(out_valid), 1);
      check("byp_pc", out_pc, 32'h80);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("byp_count", 32'(count), 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
